// File: rtl/snake_draw_sched_if.sv
// Request/grant bundle between the snake/apple control FSMs and
// the draw scheduler: level requests with origins, one-hot grant/done.
interface snake_draw_sched_if;
    logic [2:0]  req;
    logic [23:0] x_in;
    logic [20:0] y_in;
    logic [8:0]  col_in;
    logic [2:0]  grant;
    logic [2:0]  done;
    logic        busy;

    modport master (
        output req, x_in, y_in, col_in,
        input  grant, done, busy
    );

    modport slave (
        input  req, x_in, y_in, col_in,
        output grant, done, busy
    );
endinterface

// File: rtl/snake_draw_sched.sv
// Arbitrates erase/head/apple block paints onto the single vga_adapter
// plot port, scanning each BLK x BLK block in raster order.
module snake_draw_sched #(
    parameter int BLK     = 10,
    parameter int XSCREEN = 160,
    parameter int YSCREEN = 120
) (
    input  logic               CLOCK_50,
    input  logic               Resetn,
    snake_draw_sched_if.slave  rq,
    output logic [7:0]         vga_x,
    output logic [6:0]         vga_y,
    output logic [2:0]         vga_colour,
    output logic               plot
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLOT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST = 4'(BLK - 1);
    localparam logic [8:0] XLIM = 9'(XSCREEN);
    localparam logic [7:0] YLIM = 8'(YSCREEN);

    state_t      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  done_q, done_d;
    logic [7:0]  bx_q, bx_d;
    logic [6:0]  by_q, by_d;
    logic [2:0]  bc_q, bc_d;
    logic [3:0]  xc_q, xc_d;
    logic [3:0]  yc_q, yc_d;
    logic [7:0]  vx_q, vx_d;
    logic [6:0]  vy_q, vy_d;
    logic [2:0]  vc_q, vc_d;
    logic        plot_q, plot_d;

    logic [2:0]  win;
    logic [8:0]  sx;
    logic [7:0]  sy;

    // Lowest set bit wins: erase > head > apple.
    assign win = rq.req & (~rq.req + 3'd1);
    assign sx  = {1'b0, bx_q} + {5'b0, xc_q};
    assign sy  = {1'b0, by_q} + {4'b0, yc_q};

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        bx_d    = bx_q;
        by_d    = by_q;
        bc_d    = bc_q;
        xc_d    = xc_q;
        yc_d    = yc_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        vc_d    = vc_q;
        plot_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                if (rq.req != 3'b000) begin
                    state_d = PLOT;
                    grant_d = win;
                    xc_d    = '0;
                    yc_d    = '0;
                    unique case (1'b1)
                        win[0]: begin
                            bx_d = rq.x_in[7:0];
                            by_d = rq.y_in[6:0];
                            bc_d = rq.col_in[2:0];
                        end
                        win[1]: begin
                            bx_d = rq.x_in[15:8];
                            by_d = rq.y_in[13:7];
                            bc_d = rq.col_in[5:3];
                        end
                        win[2]: begin
                            bx_d = rq.x_in[23:16];
                            by_d = rq.y_in[20:14];
                            bc_d = rq.col_in[8:6];
                        end
                        default: ;
                    endcase
                end
            end
            PLOT: begin
                vx_d   = sx[7:0];
                vy_d   = sy[6:0];
                vc_d   = bc_q;
                // Off-screen pixels still take their cycle.
                plot_d = (sx < XLIM) && (sy < YLIM);
                if (xc_q != LAST) begin
                    xc_d = xc_q + 4'd1;
                end else begin
                    xc_d = '0;
                    yc_d = yc_q + 4'd1;
                    if (yc_q == LAST)
                        state_d = DONE;
                end
            end
            DONE: begin
                done_d  = grant_q;
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            bc_q    <= '0;
            xc_q    <= '0;
            yc_q    <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
            vc_q    <= '0;
            plot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            bc_q    <= bc_d;
            xc_q    <= xc_d;
            yc_q    <= yc_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            vc_q    <= vc_d;
            plot_q  <= plot_d;
        end
    end

    assign rq.grant   = grant_q;
    assign rq.done    = done_q;
    assign rq.busy    = (state_q != IDLE);
    assign vga_x      = vx_q;
    assign vga_y      = vy_q;
    assign vga_colour = vc_q;
    assign plot       = plot_q;

endmodule

// File: tb/tb_snake_draw_sched.sv
// Directed bench for snake_draw_sched: cycle-count service model plus
// hand-computed literal expectations for each scenario.
module tb_snake_draw_sched;

    localparam int BLK  = 10;
    localparam int NPIX = BLK * BLK;
    localparam int XS   = 160;
    localparam int YS   = 120;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    snake_draw_sched_if bus ();

    snake_draw_sched #(.BLK(BLK), .XSCREEN(XS), .YSCREEN(YS)) dut (
        .CLOCK_50   (clk),
        .Resetn     (rstn),
        .rq         (bus),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Service model: a granted block is a count of cycles since grant.
    logic [2:0] m_win, m_grant, m_done;
    logic [7:0] m_ox, m_vx;
    logic [6:0] m_oy, m_vy;
    logic [2:0] m_oc, m_vc;
    logic       m_act, m_plot;
    int         m_cnt;

    function automatic logic [2:0] pick(input logic [2:0] r);
        if (r[0]) return 3'b001;
        if (r[1]) return 3'b010;
        return 3'b100;
    endfunction

    function automatic int idx(input logic [2:0] oh);
        return oh[0] ? 0 : (oh[1] ? 1 : 2);
    endfunction

    function automatic int px(input logic [7:0] ox, input int c);
        return int'(ox) + c % BLK;
    endfunction

    function automatic int py(input logic [6:0] oy, input int c);
        return int'(oy) + c / BLK;
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            m_act <= 0; m_cnt <= 0; m_win <= 0; m_grant <= 0; m_done <= 0;
            m_plot <= 0; m_vx <= 0; m_vy <= 0; m_vc <= 0;
            m_ox <= 0; m_oy <= 0; m_oc <= 0;
        end else if (!m_act) begin
            m_done <= 0; m_grant <= 0; m_plot <= 0;
            if (bus.req != 0) begin
                m_act   <= 1;
                m_cnt   <= 0;
                m_win   <= pick(bus.req);
                m_grant <= pick(bus.req);
                m_ox    <= bus.x_in[8*idx(pick(bus.req)) +: 8];
                m_oy    <= bus.y_in[7*idx(pick(bus.req)) +: 7];
                m_oc    <= bus.col_in[3*idx(pick(bus.req)) +: 3];
            end
        end else if (m_cnt < NPIX) begin
            m_cnt  <= m_cnt + 1;
            m_vx   <= 8'(px(m_ox, m_cnt));
            m_vy   <= 7'(py(m_oy, m_cnt));
            m_vc   <= m_oc;
            m_plot <= (px(m_ox, m_cnt) < XS) && (py(m_oy, m_cnt) < YS);
        end else begin
            m_act   <= 0;
            m_plot  <= 0;
            m_done  <= m_win;
            m_grant <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("grant", bus.grant, m_grant);
            check("done", bus.done, m_done);
            check("busy", bus.busy, m_act);
            check("plot", plot, m_plot);
            check("grant_onehot", $onehot0(bus.grant), 1);
            if (m_plot) begin
                check("vga_x", vga_x, m_vx);
                check("vga_y", vga_y, m_vy);
                check("vga_colour", vga_colour, m_vc);
            end
        end
    end

    int         np, td;
    logic [2:0] db;
    logic [7:0] fx, lx;
    logic [6:0] fy, ly;

    task automatic run(input logic [2:0] r, input int drop_at);
        np = 0; td = -1; db = 0;
        fx = 0; fy = 0; lx = 0; ly = 0;
        bus.req = r;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (plot) begin
                if (np == 0) begin fx = vga_x; fy = vga_y; end
                lx = vga_x; ly = vga_y;
                np++;
                if (np == drop_at) bus.req = 3'b000;
            end
            if (bus.done != 0) begin
                td = n; db = bus.done;
                bus.req = bus.req & ~bus.done;
                break;
            end
        end
        if (td < 0) check("done_timeout", 0, 1);
    endtask

    initial begin
        int t[3];
        logic [2:0] b[3];
        int k;
        int ngr2;
        rstn       = 1'b0;
        bus.req    = 3'b000;
        bus.x_in   = '0;
        bus.y_in   = '0;
        bus.col_in = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_grant", bus.grant, 0);
        check("rst_plot", plot, 0);
        check("rst_vga", {vga_x, vga_y, vga_colour}, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Head block at (39,59)
        bus.x_in[15:8] = 8'd39; bus.y_in[13:7] = 7'd59; bus.col_in[5:3] = 3'b010;
        run(3'b010, 0);
        check("head_plots", np, 100);
        check("head_done_cyc", td, 102);
        check("head_done_bits", db, 3'b010);
        check("head_first", {fx, fy}, {8'd39, 7'd59});
        check("head_last", {lx, ly}, {8'd48, 7'd68});
        repeat (3) @(negedge clk);
        check("head_idle_grant", bus.grant, 0);

        // All three at once
        bus.x_in[7:0] = 8'd0;    bus.y_in[6:0] = 7'd0;    bus.col_in[2:0] = 3'b001;
        bus.x_in[23:16] = 8'd70; bus.y_in[20:14] = 7'd30; bus.col_in[8:6] = 3'b100;
        bus.req = 3'b111;
        k = 0;
        for (int n = 1; n <= 1000 && k < 3; n++) begin
            @(negedge clk);
            if (bus.done != 0) begin
                t[k] = n; b[k] = bus.done; k++;
                bus.req = bus.req & ~bus.done;
            end
        end
        check("all_count", k, 3);
        if (k == 3) begin
            check("all_order0", b[0], 3'b001);
            check("all_order1", b[1], 3'b010);
            check("all_order2", b[2], 3'b100);
            check("all_t0", t[0], 102);
            check("all_gap01", t[1] - t[0], 102);
            check("all_gap12", t[2] - t[1], 102);
        end
        repeat (2) @(negedge clk);

        // Clipped apple at (155,115)
        bus.x_in[23:16] = 8'd155; bus.y_in[20:14] = 7'd115;
        run(3'b100, 0);
        check("clip_plots", np, 25);
        check("clip_done_cyc", td, 102);
        check("clip_first", {fx, fy}, {8'd155, 7'd115});
        check("clip_last", {lx, ly}, {8'd159, 7'd119});
        repeat (2) @(negedge clk);

        // Reset in the middle of an erase block
        bus.x_in[7:0] = 8'd20; bus.y_in[6:0] = 7'd10; bus.col_in[2:0] = 3'b011;
        bus.req = 3'b001;
        np = 0;
        for (int n = 1; n <= 200 && np < 50; n++) begin
            @(negedge clk);
            if (plot) np++;
        end
        check("mid_reached", np, 50);
        rstn = 1'b0;
        @(negedge clk);
        check("mid_rst_outs", {bus.grant, bus.done, bus.busy, plot}, 0);
        check("mid_rst_vga", {vga_x, vga_y, vga_colour}, 0);
        rstn = 1'b1;
        run(3'b001, 0);
        check("mid_restart_first", {fx, fy}, {8'd20, 7'd10});
        check("mid_restart_plots", np, 100);
        check("mid_restart_done", td, 102);
        repeat (2) @(negedge clk);

        // Head request dropped at pixel 10
        bus.x_in[15:8] = 8'd0; bus.y_in[13:7] = 7'd0;
        run(3'b010, 10);
        check("drop_plots", np, 100);
        check("drop_done_bits", db, 3'b010);
        repeat (5) @(negedge clk);
        check("drop_idle", {bus.grant, bus.busy, plot}, 0);

        // Erase held through done starves apple
        bus.req = 3'b101;
        k = 0; ngr2 = 0;
        for (int n = 1; n <= 600 && k < 2; n++) begin
            @(negedge clk);
            if (bus.grant[2]) ngr2++;
            if (bus.done != 0) begin
                t[k] = n; b[k] = bus.done; k++;
            end
        end
        bus.req = 3'b000;
        check("held_count", k, 2);
        if (k == 2) begin
            check("held_bits0", b[0], 3'b001);
            check("held_bits1", b[1], 3'b001);
            check("held_period", t[1] - t[0], 102);
        end
        check("held_no_apple", ngr2, 0);
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
